// File: rtl/add_round_key_sched.sv
// AES-128 AddRoundKey with an on-the-fly key schedule.
// Each accepted state is XORed with the current round key, then the schedule
// advances by one round; after round NR it rewinds to the stored cipher key.
module add_round_key_sched #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned NR     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_load,
    input  logic [DATA_W-1:0] key_in,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        round_out,
    output logic              last_out,
    output logic              err_out
);

    localparam logic [3:0] LastRound = 4'(NR);

    // FIPS-197 S-box, entry 0 in the top byte.
    localparam logic [2047:0] SboxTbl = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // Byte x sits at bit offset 8*(255-x) == {~x, 3'b000}.
        return SboxTbl[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [DATA_W-1:0] cipher_key_q, cipher_key_d;
    logic [DATA_W-1:0] rk_q, rk_d;
    logic [3:0]        round_q, round_d;
    logic [7:0]        rcon_q, rcon_d;
    logic              key_valid_q, key_valid_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [3:0]        round_out_q, round_out_d;
    logic              valid_out_q, valid_out_d;
    logic              last_out_q, last_out_d;
    logic              err_out_q, err_out_d;

    logic       accept;
    logic [7:0] rcon_eff;

    // Next-state: key load, beat accept, schedule advance/wrap, drop detection.
    always_comb begin
        cipher_key_d = cipher_key_q;
        rk_d         = rk_q;
        round_d      = round_q;
        rcon_d       = rcon_q;
        key_valid_d  = key_valid_q;
        data_out_d   = data_out_q;
        round_out_d  = round_out_q;
        valid_out_d  = 1'b0;
        last_out_d   = 1'b0;

        accept    = valid_in & key_valid_q & ~key_load;
        err_out_d = valid_in & ~accept;
        // rcon_q holds the constant used by the previous expansion; round 0 uses it as-is.
        rcon_eff  = (round_q != 4'd0) ? xtime(rcon_q) : rcon_q;

        if (key_load) begin
            cipher_key_d = key_in;
            rk_d         = key_in;
            round_d      = 4'd0;
            rcon_d       = 8'h01;
            key_valid_d  = 1'b1;
        end else if (accept) begin
            data_out_d  = data_in ^ rk_q;
            round_out_d = round_q;
            last_out_d  = (round_q == LastRound);
            valid_out_d = 1'b1;
            if (round_q == LastRound) begin
                round_d = 4'd0;
                rk_d    = cipher_key_q;
                rcon_d  = 8'h01;
            end else begin
                round_d = round_q + 4'd1;
                rk_d    = key_next(rk_q, rcon_eff);
                rcon_d  = rcon_eff;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cipher_key_q <= '0;
            rk_q         <= '0;
            round_q      <= 4'd0;
            rcon_q       <= 8'h01;
            key_valid_q  <= 1'b0;
            data_out_q   <= '0;
            round_out_q  <= 4'd0;
            valid_out_q  <= 1'b0;
            last_out_q   <= 1'b0;
            err_out_q    <= 1'b0;
        end else begin
            cipher_key_q <= cipher_key_d;
            rk_q         <= rk_d;
            round_q      <= round_d;
            rcon_q       <= rcon_d;
            key_valid_q  <= key_valid_d;
            data_out_q   <= data_out_d;
            round_out_q  <= round_out_d;
            valid_out_q  <= valid_out_d;
            last_out_q   <= last_out_d;
            err_out_q    <= err_out_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign round_out = round_out_q;
    assign last_out  = last_out_q;
    assign err_out   = err_out_q;

endmodule
